// File: rtl/jtag_dbg_ctrl.sv
// Core-clock sequencer for the LM32 JTAG debug register: synchronises update frames,
// decodes debug commands and runs byte-wide bus accesses. Optional: DBG_TIMEOUT_EN (bus watchdog).
module jtag_dbg_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        reg_update_i,
  input  logic [7:0]  reg_q_i,
  input  logic [2:0]  reg_addr_q_i,
  output logic [7:0]  reg_d_o,
  output logic [2:0]  reg_addr_d_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_err_i,
  output logic        break_o
);

  typedef enum logic [1:0] {IDLE, ARG, BUS} state_e;
  typedef enum logic [2:0] {
    CMD_NOP, CMD_READ_MEM, CMD_WRITE_MEM, CMD_READ_NEXT,
    CMD_WRITE_NEXT, CMD_BREAK, CMD_RSVD6, CMD_RSVD7
  } cmd_e;

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("jtag_dbg_ctrl: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   upd_q;
  logic                   evt;
  logic [2:0]             arg_cnt_q;
  logic                   we_q;
  logic [31:0]            addr_q;
  logic [7:0]             wdata_q;
  logic [7:0]             rdata_q;
  logic                   err_q;
  logic                   ovr_q;
  logic                   brk_q;
  logic                   timeout;
  cmd_e                   cmd;

  assign cmd = cmd_e'(reg_addr_q_i);
  assign evt = sync_q[SYNC_STAGES-1] & ~upd_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], reg_update_i};
      upd_q  <= sync_q[SYNC_STAGES-1];
    end
  end

`ifdef DBG_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)            wd_q <= '0;
    else if (state_q == BUS) wd_q <= wd_q + 1'b1;
    else                     wd_q <= '0;
  end

  assign timeout = (state_q == BUS) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: defaulting state_d first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (evt) begin
        if (cmd inside {CMD_READ_MEM, CMD_WRITE_MEM, CMD_WRITE_NEXT}) state_d = ARG;
        else if (cmd == CMD_READ_NEXT)                                 state_d = BUS;
      end
      ARG:  if (evt && arg_cnt_q == 3'd1) state_d = BUS;
      BUS:  if (mem_err_i || mem_ack_i || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o    = (state_q == BUS);
    reg_addr_d_o = {ovr_q, err_q, state_q != IDLE};
  end

  assign reg_d_o     = rdata_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign break_o     = brk_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      arg_cnt_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      brk_q <= 1'b0;
      unique case (state_q)
        IDLE: if (evt) begin
          unique case (cmd)
            CMD_NOP:        begin err_q <= 1'b0; ovr_q <= 1'b0; end
            CMD_READ_MEM:   begin we_q <= 1'b0; arg_cnt_q <= 3'd4; end
            CMD_WRITE_MEM:  begin we_q <= 1'b1; arg_cnt_q <= 3'd5; end
            CMD_READ_NEXT:  begin we_q <= 1'b0; addr_q <= addr_q + 32'd1; end
            CMD_WRITE_NEXT: begin we_q <= 1'b1; arg_cnt_q <= 3'd1; addr_q <= addr_q + 32'd1; end
            CMD_BREAK:      brk_q <= 1'b1;
            default:        err_q <= 1'b1;
          endcase
        end
        // Writes take their last argument byte as data; every earlier byte is address.
        ARG: if (evt) begin
          arg_cnt_q <= arg_cnt_q - 3'd1;
          if (we_q && arg_cnt_q == 3'd1) wdata_q <= reg_q_i;
          else                           addr_q  <= {addr_q[23:0], reg_q_i};
        end
        BUS: begin
          if (evt)                         ovr_q   <= 1'b1;
          if (mem_err_i || timeout)        err_q   <= 1'b1;
          else if (mem_ack_i && !we_q)     rdata_q <= mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_dbg_ctrl.sv
// Directed bench for jtag_dbg_ctrl: command-level model predicts bus accesses,
// read data and status; one compare process checks the bus and capture data every cycle.
module tb_jtag_dbg_ctrl;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        reg_update_i;
  logic [7:0]  reg_q_i;
  logic [2:0]  reg_addr_q_i;
  logic [7:0]  reg_d_o;
  logic [2:0]  reg_addr_d_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_rdata_i = 8'h00;
  logic        mem_err_i = 1'b0;
  logic        break_o;

  jtag_dbg_ctrl #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .reg_update_i(reg_update_i),
    .reg_q_i(reg_q_i), .reg_addr_q_i(reg_addr_q_i), .reg_d_o(reg_d_o),
    .reg_addr_d_o(reg_addr_d_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .break_o(break_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } acc_t;

  // Model state: expected accesses, address pointer, read byte and sticky flags.
  acc_t        exp_q[$];
  acc_t        cur;
  logic [31:0] m_addr = '0;
  logic [7:0]  m_rd = '0;
  logic        m_err = 1'b0, m_ovr = 1'b0;

  int   checks = 0, failures = 0;
  int   slave_delay = 1;
  int   slave_mode = 0;           // 0 ack, 1 err, 2 ack+err together
  logic [7:0] slave_rdata = 8'h00;
  int   req_cnt = 0, drop_cnt = -1, brk_cnt = 0;
  bit   active = 0, resp_last = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: answers the head-of-queue access after slave_delay request cycles.
  always @(posedge clk_i) begin
    #2;
    if (!rst_n_i) begin
      mem_ack_i = 1'b0; mem_err_i = 1'b0; active = 0;
    end else if (mem_ack_i || mem_err_i) begin
      mem_ack_i = 1'b0; mem_err_i = 1'b0;
      if (slave_mode != 0) m_err = 1'b1;
      else if (!cur.we)    m_rd = slave_rdata;
      active = 0;
    end else if (mem_req_o) begin
      if (!active && exp_q.size() > 0) begin
        cur = exp_q.pop_front(); active = 1; req_cnt = 0;
      end
      req_cnt++;
      if (active && req_cnt == slave_delay) begin
        mem_ack_i   = (slave_mode != 1);
        mem_err_i   = (slave_mode != 0);
        mem_rdata_i = (slave_mode == 0) ? slave_rdata : 8'hEE;
      end
    end else if (active) begin
      active = 0; drop_cnt = req_cnt;
    end
  end

  // Compare process.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      resp_last = 0;
    end else begin
      if (break_o) brk_cnt++;
      check("reg_d", reg_d_o, m_rd);
      if (resp_last) check("req_drop_after_resp", mem_req_o, 1'b0);
      resp_last = mem_ack_i | mem_err_i;
      if (mem_req_o) begin
        check("req_expected", active, 1'b1);
        if (active) begin
          check("bus_we", mem_we_o, cur.we);
          check("bus_addr", mem_addr_o, cur.addr);
          if (cur.we) check("bus_wdata", mem_wdata_o, cur.wdata);
        end
      end
    end
  end

  task automatic send_frame(input logic [2:0] code, input logic [7:0] data);
    @(negedge clk_i);
    reg_addr_q_i = code; reg_q_i = data; reg_update_i = 1'b1;
    repeat (4) @(negedge clk_i);
    reg_update_i = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic send_addr(input logic [31:0] a);
    for (int i = 3; i >= 0; i--) send_frame(3'd6, a[8*i +: 8]);
  endtask

  task automatic read_mem(input logic [31:0] a);
    m_addr = a; exp_q.push_back('{1'b0, a, 8'h00});
    send_frame(3'd1, 8'h77);
    send_addr(a);
  endtask

  task automatic write_mem(input logic [31:0] a, input logic [7:0] d);
    m_addr = a; exp_q.push_back('{1'b1, a, d});
    send_frame(3'd2, 8'h00);
    send_addr(a);
    send_frame(3'd7, d);
  endtask

  task automatic read_next();
    m_addr = m_addr + 32'd1; exp_q.push_back('{1'b0, m_addr, 8'h00});
    send_frame(3'd3, 8'hFF);
  endtask

  task automatic write_next(input logic [7:0] d);
    m_addr = m_addr + 32'd1; exp_q.push_back('{1'b1, m_addr, d});
    send_frame(3'd4, 8'h00);
    send_frame(3'd1, d);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((reg_addr_d_o[0] || mem_req_o) && n < 500) begin
      @(negedge clk_i); n++;
    end
    repeat (2) @(negedge clk_i);
    check({name, "_idle"}, {reg_addr_d_o[0], mem_req_o}, 2'b00);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_status"}, reg_addr_d_o, {m_ovr, m_err, 1'b0});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    rst_n_i = 1'b0; reg_update_i = 1'b0; reg_q_i = '0; reg_addr_q_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_outputs", {reg_d_o, reg_addr_d_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, break_o},
          '0);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Read at 0x00001004, ack after 3 cycles with 0xA5.
    slave_delay = 3; slave_mode = 0; slave_rdata = 8'hA5;
    read_mem(32'h0000_1004);
    wait_idle("t1");
    check("t1_rd_lit", reg_d_o, 8'hA5);
    check("t1_status_lit", reg_addr_d_o, 3'b000);
    check("t1_addr_lit", mem_addr_o, 32'h0000_1004);

    // Write at 0xFFFFFFFF, then WRITE_NEXT wraps to 0.
    slave_delay = 2;
    write_mem(32'hFFFF_FFFF, 8'h3C);
    wait_idle("t2a");
    write_next(8'h7E);
    wait_idle("t2b");
    check("t2_wrap_lit", mem_addr_o, 32'h0000_0000);
    check("t2_rd_kept_lit", reg_d_o, 8'hA5);

    slave_delay = 1; slave_rdata = 8'h5A;
    read_next();
    wait_idle("t2c");
    check("t2c_rd_lit", reg_d_o, 8'h5A);

    // Error on READ_NEXT, then NOP clears.
    slave_mode = 1; slave_delay = 2;
    read_next();
    wait_idle("t3");
    check("t3_status_lit", reg_addr_d_o, 3'b010);
    check("t3_rd_lit", reg_d_o, 8'h5A);
    send_frame(3'd0, 8'h00); m_err = 1'b0;
    wait_idle("t3_nop");

    // Ack and error together: error wins.
    slave_mode = 2; slave_rdata = 8'hC3;
    read_next();
    wait_idle("t3b");
    check("t3b_rd_lit", reg_d_o, 8'h5A);
    send_frame(3'd0, 8'h00); m_err = 1'b0;
    wait_idle("t3b_nop");

    // Frame during a 50-cycle stall is dropped and sets overrun.
    slave_mode = 0; slave_delay = 50; slave_rdata = 8'h99;
    read_mem(32'h0000_ABCD);
    send_frame(3'd6, 8'h11); m_ovr = 1'b1;
    wait_idle("t4");
    check("t4_status_lit", reg_addr_d_o, 3'b100);
    check("t4_rd_lit", reg_d_o, 8'h99);
    send_frame(3'd0, 8'h00); m_ovr = 1'b0;
    wait_idle("t4_nop");

    // BREAK pulse, then reserved commands set err without bus activity.
    b0 = brk_cnt;
    send_frame(3'd5, 8'h00);
    wait_idle("t5_brk");
    check("t5_brk_cycles", brk_cnt - b0, 1);
    send_frame(3'd6, 8'h00); m_err = 1'b1;
    wait_idle("t5_cmd6");
    check("t5_cmd6_lit", reg_addr_d_o, 3'b010);
    send_frame(3'd0, 8'h00); m_err = 1'b0;
    send_frame(3'd7, 8'h00); m_err = 1'b1;
    wait_idle("t5_cmd7");

`ifdef DBG_TIMEOUT_EN
    // Slave never answers: watchdog drops the request after TO cycles.
    send_frame(3'd0, 8'h00); m_err = 1'b0;
    slave_delay = 0; drop_cnt = -1;
    read_next(); m_err = 1'b1;
    wait_idle("t6");
    check("t6_req_cycles", drop_cnt, TO);
    check("t6_status_lit", reg_addr_d_o, 3'b010);
`else
    // Slave never answers: BUS waits, then async reset abandons the access.
    send_frame(3'd0, 8'h00); m_err = 1'b0;
    slave_delay = 0;
    read_next();
    repeat (300) @(negedge clk_i);
    check("t6_still_req", {mem_req_o, reg_addr_d_o}, 4'b1001);
    #2 rst_n_i = 1'b0;
    #1 check("t6_rst_drop", {mem_req_o, reg_addr_d_o, reg_d_o, mem_addr_o}, '0);
    m_addr = '0; m_rd = '0; m_err = 1'b0; m_ovr = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    slave_delay = 2; slave_rdata = 8'h42;
    read_next();
    wait_idle("t6_after_rst");
    check("t6_addr_lit", mem_addr_o, 32'h0000_0001);
`endif

    check("break_total", brk_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
